// File: rtl/aes_block_packer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_block_packer
//  Description : Collects 32-bit stream words into 128-bit AES blocks and
//                presents each completed block on a valid/ready port.
//                Word 0 of a block sits in bits [31:0].
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_block_packer #(
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 128,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic [DATA_WIDTH/8-1:0] in_strb_i,
  output logic                    blk_valid_o,
  input  logic                    blk_ready_i,
  output logic [BLOCK_WIDTH-1:0]  blk_data_o,
  output logic [1:0]              word_cnt_o,
  output logic [CNT_WIDTH-1:0]    blocks_o,
  output logic                    strb_err_o
);

  localparam int c_WORDS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int c_BYTES = DATA_WIDTH / 8;

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e                 r_state;
  logic [1:0]             r_cnt;
  logic [CNT_WIDTH-1:0]   r_blocks;
  logic                   r_strb_err;
  logic [DATA_WIDTH-1:0]  r_buf [c_WORDS];

  logic                   w_in_hs;
  logic                   w_blk_hs;
  logic [DATA_WIDTH-1:0]  w_masked;

  // A full block frees its buffer in the same cycle it is taken, so the
  // upstream may keep streaming whenever the datapath is ready.
  assign in_ready_o  = (r_state == ST_FILL) || blk_ready_i;
  assign blk_valid_o = (r_state == ST_FULL);
  assign w_in_hs     = in_valid_i && in_ready_o;
  assign w_blk_hs    = blk_valid_o && blk_ready_i;
  assign word_cnt_o  = r_cnt;
  assign blocks_o    = r_blocks;
  assign strb_err_o  = r_strb_err;

  // Bytes with a cleared strobe are stored as zero.
  generate
    for (genvar b = 0; b < c_BYTES; b++) begin : g_strb
      assign w_masked[b*8 +: 8] = in_strb_i[b] ? in_data_i[b*8 +: 8] : 8'h00;
    end
  endgenerate

  // Block output is driven straight from the buffer registers.
  generate
    for (genvar s = 0; s < c_WORDS; s++) begin : g_slot
      assign blk_data_o[s*DATA_WIDTH +: DATA_WIDTH] = r_buf[s];
    end
  endgenerate

  // Fill/present state machine with buffer, counters and sticky strobe error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_FILL;
      r_cnt      <= 2'd0;
      r_blocks   <= '0;
      r_strb_err <= 1'b0;
      for (int i = 0; i < c_WORDS; i++) r_buf[i] <= '0;
    end else if (clear_i) begin
      // Soft clear wins over any handshake in the same cycle.
      r_state    <= ST_FILL;
      r_cnt      <= 2'd0;
      r_blocks   <= '0;
      r_strb_err <= 1'b0;
      for (int i = 0; i < c_WORDS; i++) r_buf[i] <= '0;
    end else begin
      if (w_blk_hs) begin
        r_blocks <= r_blocks + CNT_WIDTH'(1);
        r_state  <= ST_FILL;
      end
      if (w_in_hs) begin
        // In FULL the count is already 0, so an overlapping word opens the
        // next block at slot 0.
        r_buf[r_cnt] <= w_masked;
        r_cnt        <= r_cnt + 2'd1;
        if (r_cnt == 2'(c_WORDS - 1)) r_state <= ST_FULL;
        if (in_strb_i != {c_BYTES{1'b1}}) r_strb_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_block_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_block_packer
//  Description : Self-checking bench for aes_block_packer. A queue of accepted
//                words forms the reference: four queued words mean a block is
//                on offer, and the front four are the block contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_block_packer;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         clear_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_data_i;
  logic [3:0]   in_strb_i;
  logic         blk_valid_o;
  logic         blk_ready_i;
  logic [127:0] blk_data_o;
  logic [1:0]   word_cnt_o;
  logic [15:0]  blocks_o;
  logic         strb_err_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] q[$];
  int          exp_blocks = 0;
  bit          exp_err = 0;

  always #5 clk_i = ~clk_i;

  aes_block_packer #(
    .DATA_WIDTH (32),
    .BLOCK_WIDTH(128),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_strb_i  (in_strb_i),
    .blk_valid_o(blk_valid_o),
    .blk_ready_i(blk_ready_i),
    .blk_data_o (blk_data_o),
    .word_cnt_o (word_cnt_o),
    .blocks_o   (blocks_o),
    .strb_err_o (strb_err_o)
  );

  function automatic logic [31:0] mask_word(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // One clock: drive at negedge, compare outputs against the queue model,
  // advance the model, then return at posedge+1 with the new state settled.
  task automatic step(input bit v, input logic [31:0] d, input logic [3:0] s,
                      input bit br, input bit clr, output bit acc);
    bit           full;
    bit           m_acc;
    logic [127:0] eb;
    logic [31:0]  dummy;
    @(negedge clk_i);
    in_valid_i = v; in_data_i = d; in_strb_i = s; blk_ready_i = br; clear_i = clr;
    #1;
    full = (q.size() == 4);
    checks++;
    if (in_ready_o !== (!full || br)) begin
      errors++; $display("FAIL in_ready: got %b want %b", in_ready_o, (!full || br));
    end
    checks++;
    if (blk_valid_o !== full) begin
      errors++; $display("FAIL blk_valid: got %b want %b", blk_valid_o, full);
    end
    checks++;
    if (word_cnt_o !== 2'(q.size() % 4)) begin
      errors++; $display("FAIL word_cnt: got %0d want %0d", word_cnt_o, q.size() % 4);
    end
    checks++;
    if (blocks_o !== 16'(exp_blocks)) begin
      errors++; $display("FAIL blocks: got %0d want %0d", blocks_o, exp_blocks);
    end
    checks++;
    if (strb_err_o !== exp_err) begin
      errors++; $display("FAIL strb_err: got %b want %b", strb_err_o, exp_err);
    end
    if (full) begin
      eb = {q[3], q[2], q[1], q[0]};
      checks++;
      if (blk_data_o !== eb) begin
        errors++; $display("FAIL blk_data: got %h want %h", blk_data_o, eb);
      end
    end
    acc   = v && in_ready_o;
    m_acc = v && (!full || br);
    if (clr) begin
      q.delete(); exp_blocks = 0; exp_err = 0;
    end else begin
      if (full && br) begin
        for (int i = 0; i < 4; i++) dummy = q.pop_front();
        exp_blocks = (exp_blocks + 1) % 65536;
      end
      if (m_acc) begin
        q.push_back(mask_word(d, s));
        if (s != 4'hF) exp_err = 1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid_i = 0; clear_i = 0; blk_ready_i = 0; in_data_i = '0; in_strb_i = 4'hF;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (in_ready_o !== 1'b1 || blk_valid_o !== 1'b0 || blk_data_o !== 128'h0 ||
        word_cnt_o !== 2'd0 || blocks_o !== 16'd0 || strb_err_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: got rdy=%b vld=%b data=%h cnt=%0d blk=%0d err=%b want 1 0 0 0 0 0",
               tag, in_ready_o, blk_valid_o, blk_data_o, word_cnt_o, blocks_o, strb_err_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 0;
    #13;
    check_reset_values("reset_values");
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_basic();
    bit a;
    step(0, 0, 4'hF, 1, 1, a);
    step(1, 32'h00112233, 4'hF, 1, 0, a);
    step(1, 32'h44556677, 4'hF, 1, 0, a);
    step(1, 32'h8899AABB, 4'hF, 1, 0, a);
    step(1, 32'hCCDDEEFF, 4'hF, 1, 0, a);
    checks++;
    if (blk_valid_o !== 1'b1 || blk_data_o !== 128'hCCDDEEFF_8899AABB_44556677_00112233) begin
      errors++; $display("FAIL basic_block: got vld=%b %h want 1 ccddeeff8899aabb4455667700112233",
                         blk_valid_o, blk_data_o);
    end
    step(0, 0, 4'hF, 1, 0, a);
    checks++;
    if (blk_valid_o !== 1'b0 || blocks_o !== 16'd1) begin
      errors++; $display("FAIL basic_release: got vld=%b blocks=%0d want 0 1", blk_valid_o, blocks_o);
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    int n_acc;
    int base;
    step(0, 0, 4'hF, 1, 0, a);
    base  = exp_blocks;
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, $urandom, 4'hF, 1, 0, a);
      if (a) n_acc++;
    end
    checks++;
    if (n_acc != 12) begin
      errors++; $display("FAIL b2b_words: got %0d want 12", n_acc);
    end
    step(0, 0, 4'hF, 1, 0, a);
    checks++;
    if (blocks_o !== 16'(base + 3)) begin
      errors++; $display("FAIL b2b_blocks: got %0d want %0d", blocks_o, base + 3);
    end
  endtask

  task automatic test_stall();
    bit           a;
    logic [127:0] held;
    logic [31:0]  w [4];
    logic [31:0]  nw;
    int           base;
    base = exp_blocks;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      step(1, w[i], 4'hF, 0, 0, a);
    end
    held = {w[3], w[2], w[1], w[0]};
    for (int i = 0; i < 5; i++) begin
      step(1, $urandom, 4'hF, 0, 0, a);
      checks++;
      if (in_ready_o !== 1'b0 || blk_data_o !== held || blk_valid_o !== 1'b1) begin
        errors++; $display("FAIL stall_hold: got rdy=%b vld=%b %h want 0 1 %h",
                           in_ready_o, blk_valid_o, blk_data_o, held);
      end
    end
    nw = $urandom;
    step(1, nw, 4'hF, 1, 0, a);
    checks++;
    if (word_cnt_o !== 2'd1 || blk_data_o[31:0] !== nw || blk_valid_o !== 1'b0 ||
        blocks_o !== 16'(base + 1)) begin
      errors++; $display("FAIL stall_release: got cnt=%0d slot0=%h vld=%b blocks=%0d want 1 %h 0 %0d",
                         word_cnt_o, blk_data_o[31:0], blk_valid_o, blocks_o, nw, base + 1);
    end
    for (int i = 0; i < 3; i++) step(1, $urandom, 4'hF, 1, 0, a);
    step(0, 0, 4'hF, 1, 0, a);
  endtask

  task automatic test_strobe();
    bit a;
    step(0, 0, 4'hF, 1, 1, a);
    step(1, 32'hFFFFFFFF, 4'b0101, 1, 0, a);
    checks++;
    if (blk_data_o[31:0] !== 32'h00FF00FF || strb_err_o !== 1'b1) begin
      errors++; $display("FAIL strobe_mask: got slot0=%h err=%b want 00ff00ff 1",
                         blk_data_o[31:0], strb_err_o);
    end
    for (int i = 0; i < 11; i++) step(1, $urandom, 4'hF, 1, 0, a);
    step(0, 0, 4'hF, 1, 0, a);
    checks++;
    if (strb_err_o !== 1'b1) begin
      errors++; $display("FAIL strobe_sticky: got %b want 1", strb_err_o);
    end
  endtask

  task automatic test_clear();
    bit a;
    step(1, $urandom, 4'hF, 1, 0, a);
    step(1, $urandom, 4'h3, 1, 0, a);
    step(1, 32'hDEADBEEF, 4'hF, 1, 1, a);
    checks++;
    if (word_cnt_o !== 2'd0 || strb_err_o !== 1'b0 || blocks_o !== 16'd0 || blk_data_o !== 128'h0) begin
      errors++; $display("FAIL clear: got cnt=%0d err=%b blocks=%0d data=%h want 0 0 0 0",
                         word_cnt_o, strb_err_o, blocks_o, blk_data_o);
    end
    step(1, 32'h11111111, 4'hF, 1, 0, a);
    step(1, 32'h22222222, 4'hF, 1, 0, a);
    step(1, 32'h33333333, 4'hF, 1, 0, a);
    step(1, 32'h44444444, 4'hF, 1, 0, a);
    checks++;
    if (blk_data_o !== 128'h44444444_33333333_22222222_11111111 || strb_err_o !== 1'b0) begin
      errors++; $display("FAIL clear_block: got %h err=%b want 44444444333333332222222211111111 0",
                         blk_data_o, strb_err_o);
    end
    step(0, 0, 4'hF, 1, 0, a);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_ni = 0;
    #1;
    check_reset_values(tag);
    q.delete(); exp_blocks = 0; exp_err = 0;
    idle_inputs();
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_async_reset();
    bit a;
    step(1, $urandom, 4'hF, 1, 0, a);
    step(1, $urandom, 4'h1, 1, 0, a);
    async_reset("reset_midblock");
    for (int i = 0; i < 4; i++) step(1, $urandom, 4'hF, 0, 0, a);
    step(0, 0, 4'hF, 0, 0, a);
    async_reset("reset_full");
    for (int i = 0; i < 4; i++) step(1, $urandom, 4'hF, 1, 0, a);
    step(0, 0, 4'hF, 1, 0, a);
  endtask

  task automatic test_random();
    bit         a;
    logic [3:0] s;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      step(bit'($urandom_range(0, 3) != 0), $urandom, s,
           bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 60) == 0), a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_strobe();
    test_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
